// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings and helpers for the hazard controller
// Contents: forward-select encodings, req/ack FSM state encodings with
// data-path (D_*) and fetch-path (F_*) aliases, register match helpers.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_M  = 2'b01,
      FWD_WB = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } req_state_e;

   // Both memory paths share one FSM; these name its states per path.
   localparam req_state_e D_IDLE    = ST_IDLE;
   localparam req_state_e D_WAIT    = ST_WAIT;
   localparam req_state_e F_IDLE    = ST_IDLE;
   localparam req_state_e F_WAIT    = ST_WAIT;
   localparam req_state_e F_DISCARD = ST_DISCARD;

   // $0 is hardwired zero, so it never aliases a producer.
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   // The M result is younger than WB, so it takes priority.
   function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                           input logic       m_we,
                                           input logic [4:0] m_rd,
                                           input logic       wb_we,
                                           input logic [4:0] wb_rd);
      if (m_we && reg_match(src, m_rd))
         return FWD_M;
      else if (wb_we && reg_match(src, wb_rd))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status/control bundle for the hazard controller
// master: pipeline side (drives register numbers, control bits, acks, flush request)
// slave : controller side (drives requests, stalls, flushes, forward selects, perf count)
interface pipeline_hazard_ctrl_if;
   logic [4:0]  ID_Rs, ID_Rt, EX_Rs, EX_Rt;
   logic        ID_NeedRs, ID_NeedRt, EX_NeedRs, EX_NeedRt;
   logic [4:0]  EX_RtRd, M_RtRd, WB_RtRd;
   logic        EX_RegWrite, M_RegWrite, WB_RegWrite, M_MemRead, M_MemWrite;
   logic        IMem_Ack, DMem_Ack, ALU_Busy, Exc_Flush;
   logic        IMem_Req, DMem_Req;
   logic        IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall;
   logic        IF_Flush, ID_Flush, EX_Flush;
   logic [1:0]  ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel;
   logic [31:0] Perf_StallCycles;

   modport master (
      output ID_Rs, ID_Rt, EX_Rs, EX_Rt,
      output ID_NeedRs, ID_NeedRt, EX_NeedRs, EX_NeedRt,
      output EX_RtRd, M_RtRd, WB_RtRd,
      output EX_RegWrite, M_RegWrite, WB_RegWrite, M_MemRead, M_MemWrite,
      output IMem_Ack, DMem_Ack, ALU_Busy, Exc_Flush,
      input  IMem_Req, DMem_Req,
      input  IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall,
      input  IF_Flush, ID_Flush, EX_Flush,
      input  ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel,
      input  Perf_StallCycles
   );

   modport slave (
      input  ID_Rs, ID_Rt, EX_Rs, EX_Rt,
      input  ID_NeedRs, ID_NeedRt, EX_NeedRs, EX_NeedRt,
      input  EX_RtRd, M_RtRd, WB_RtRd,
      input  EX_RegWrite, M_RegWrite, WB_RegWrite, M_MemRead, M_MemWrite,
      input  IMem_Ack, DMem_Ack, ALU_Busy, Exc_Flush,
      output IMem_Req, DMem_Req,
      output IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall,
      output IF_Flush, ID_Flush, EX_Flush,
      output ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel,
      output Perf_StallCycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_mem_req_fsm.sv
// rtl/pipeline_hazard_ctrl_mem_req_fsm.sv - req/ack memory handshake FSM (module mem_req_fsm)
// Ports: clock, reset (sync active-high); want (access needed this cycle),
// ack (memory ack), discard (abandon an outstanding access); req (request
// level), stall (stage must hold: access incomplete or word being discarded).
module mem_req_fsm
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic want,
   input  logic ack,
   input  logic discard,
   output logic req,
   output logic stall
);

   req_state_e state, state_next;

   always_ff @(posedge clock) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      req        = 1'b0;
      stall      = 1'b0;
      case (state)
         ST_IDLE: begin
            req = want;
            if (want && !ack)
               state_next = ST_WAIT;
         end
         ST_WAIT: begin
            req = 1'b1;
            if (ack)
               state_next = ST_IDLE;
            else if (discard)
               state_next = ST_DISCARD;
         end
         ST_DISCARD: begin
            // Request dropped, but the memory still owes one ack; that word
            // is swallowed, so the stage stays held through the ack cycle.
            stall = 1'b1;
            if (ack)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (state != ST_DISCARD)
         stall = req & ~ack;
      if (reset) begin
         req   = 1'b0;
         stall = 1'b0;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and memory-wait controller
// Ports: clock, reset (sync active-high), bus (pipeline_hazard_ctrl_if.slave):
// stage register numbers/need bits, in-flight control bits, memory acks,
// ALU busy and exception flush in; memory requests, stage stalls/flushes,
// operand forward selects and stall-cycle count out.
// Option: define HAZARD_PERF_CNT_EN to build the IF stall-cycle counter;
// otherwise Perf_StallCycles is tied to 0.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
(
   input logic                   clock,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave bus
);

   logic dmem_want, dmem_req, imem_req;
   logic m_stall, fetch_stall;
   logic id_data_stall, ex_data_stall;
   logic ex_stall, id_stall, if_stall;
   logic flush;

   assign dmem_want = bus.M_MemRead | bus.M_MemWrite;

   // Data accesses are never abandoned, even by an exception flush.
   mem_req_fsm u_data_fsm (
      .clock   (clock),
      .reset   (reset),
      .want    (dmem_want),
      .ack     (bus.DMem_Ack),
      .discard (1'b0),
      .req     (dmem_req),
      .stall   (m_stall)
   );

   mem_req_fsm u_fetch_fsm (
      .clock   (clock),
      .reset   (reset),
      .want    (1'b1),
      .ack     (bus.IMem_Ack),
      .discard (bus.Exc_Flush),
      .req     (imem_req),
      .stall   (fetch_stall)
   );

   // ID must wait for an EX producer (no EX->ID path) and for a load in M.
   assign id_data_stall =
        (bus.ID_NeedRs && ((bus.EX_RegWrite && reg_match(bus.ID_Rs, bus.EX_RtRd)) ||
                           (bus.M_MemRead   && reg_match(bus.ID_Rs, bus.M_RtRd))))
      | (bus.ID_NeedRt && ((bus.EX_RegWrite && reg_match(bus.ID_Rt, bus.EX_RtRd)) ||
                           (bus.M_MemRead   && reg_match(bus.ID_Rt, bus.M_RtRd))));

   assign ex_data_stall =
        (bus.EX_NeedRs && bus.M_MemRead && reg_match(bus.EX_Rs, bus.M_RtRd))
      | (bus.EX_NeedRt && bus.M_MemRead && reg_match(bus.EX_Rt, bus.M_RtRd));

   assign flush = bus.Exc_Flush & ~reset;

   // Data hazards are moot when the stage is being squashed; structural
   // holds (memory wait, busy ALU) still apply and chain toward IF.
   assign ex_stall = ~reset & (m_stall | bus.ALU_Busy | (ex_data_stall & ~bus.Exc_Flush));
   assign id_stall = ex_stall | (~reset & id_data_stall & ~bus.Exc_Flush);
   assign if_stall = id_stall | fetch_stall;

   assign bus.IMem_Req = imem_req;
   assign bus.DMem_Req = dmem_req;
   assign bus.IF_Stall = if_stall;
   assign bus.ID_Stall = id_stall;
   assign bus.EX_Stall = ex_stall;
   assign bus.M_Stall  = m_stall;
   assign bus.WB_Stall = 1'b0;
   assign bus.IF_Flush = flush;
   assign bus.ID_Flush = flush;
   assign bus.EX_Flush = flush;

   assign bus.ID_RsFwdSel = reset ? FWD_RF :
      fwd_select(bus.ID_Rs, bus.M_RegWrite, bus.M_RtRd, bus.WB_RegWrite, bus.WB_RtRd);
   assign bus.ID_RtFwdSel = reset ? FWD_RF :
      fwd_select(bus.ID_Rt, bus.M_RegWrite, bus.M_RtRd, bus.WB_RegWrite, bus.WB_RtRd);
   assign bus.EX_RsFwdSel = reset ? FWD_RF :
      fwd_select(bus.EX_Rs, bus.M_RegWrite, bus.M_RtRd, bus.WB_RegWrite, bus.WB_RtRd);
   assign bus.EX_RtFwdSel = reset ? FWD_RF :
      fwd_select(bus.EX_Rt, bus.M_RegWrite, bus.M_RtRd, bus.WB_RegWrite, bus.WB_RtRd);

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles;

   // Free-running; wraps from all-ones to zero.
   always_ff @(posedge clock) begin
      if (reset)
         stall_cycles <= '0;
      else if (if_stall)
         stall_cycles <= stall_cycles + 32'd1;
   end

   assign bus.Perf_StallCycles = stall_cycles;
`else
   assign bus.Perf_StallCycles = 32'd0;
`endif

endmodule
